// File: rtl/gpu_frame_reader.sv
// gpu_frame_reader: VGA scan generator that fetches an upscaled grayscale
// image from the image RAM read port, one address per pixel tick.
// Address goes out on the first clk of a pixel (E0) and the returned byte
// is captured on the second (E1), so video lags the address by one clk.
module gpu_frame_reader #(
   parameter int IMG_W  = 128,
   parameter int IMG_H  = 128,
   parameter int SCALE  = 2,
   parameter int X_OFF  = 192,
   parameter int Y_OFF  = 112,
   parameter int H_VIS  = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_VIS  = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [31:0] GPUAddress,
   input  logic [31:0] GPUData,
   output logic        vga_clk,
   output logic        vga_hsync,
   output logic        vga_vsync,
   output logic        vga_blank_n,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        frame_done
);

   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int HW    = $clog2(H_TOT);
   localparam int VW    = $clog2(V_TOT);
   localparam int SH    = $clog2(SCALE);

   logic          tick;
   logic [HW-1:0] h, h_nxt;
   logic [VW-1:0] v, v_nxt;
   logic          wrap;
   logic          win_nxt, win_cur, vis_cur, hs_cur, vs_cur;
   logic [31:0]   addr_nxt;
   logic [7:0]    pix;
   logic          unused_data;

   // only the low byte of the RAM word carries the pixel
   assign unused_data = ^GPUData[31:8];

   function automatic logic in_win(input int x, input int y);
      return (x >= X_OFF) && (x < X_OFF + IMG_W*SCALE) &&
             (y >= Y_OFF) && (y < Y_OFF + IMG_H*SCALE);
   endfunction

   // next scan position; wrap marks the last pixel of the frame
   always_comb begin
      h_nxt = h + 1'b1;
      v_nxt = v;
      wrap  = 1'b0;
      if (int'(h) == H_TOT-1) begin
         h_nxt = '0;
         if (int'(v) == V_TOT-1) begin
            v_nxt = '0;
            wrap  = 1'b1;
         end else begin
            v_nxt = v + 1'b1;
         end
      end
   end

   // image address for the position being entered; outside the window park at 0
   always_comb begin
      win_nxt  = in_win(int'(h_nxt), int'(v_nxt));
      addr_nxt = '0;
      if (win_nxt)
         addr_nxt = 32'((((int'(v_nxt) - Y_OFF) >> SH) * IMG_W) +
                        ((int'(h_nxt) - X_OFF) >> SH));
   end

   // video decode of the position already entered at the preceding E0
   always_comb begin
      win_cur = in_win(int'(h), int'(v));
      vis_cur = (int'(h) < H_VIS) && (int'(v) < V_VIS);
      hs_cur  = !((int'(h) >= H_VIS + H_FP) && (int'(h) < H_VIS + H_FP + H_SYNC));
      vs_cur  = !((int'(v) >= V_VIS + V_FP) && (int'(v) < V_VIS + V_FP + V_SYNC));
   end

   // scan state: E0 (tick=1) moves position and address, E1 (tick=0) updates video
   always_ff @(posedge clk) begin
      if (!rst) begin
         tick        <= 1'b0;
         h           <= '0;
         v           <= '0;
         GPUAddress  <= '0;
         vga_hsync   <= 1'b1;
         vga_vsync   <= 1'b1;
         vga_blank_n <= 1'b0;
         pix         <= '0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (!en) begin
            vga_blank_n <= 1'b0;
            pix         <= '0;
         end else begin
            tick <= ~tick;
            if (tick) begin
               h          <= h_nxt;
               v          <= v_nxt;
               GPUAddress <= addr_nxt;
               frame_done <= wrap;
            end else begin
               pix         <= win_cur ? GPUData[7:0] : 8'd0;
               vga_blank_n <= vis_cur;
               vga_hsync   <= hs_cur;
               vga_vsync   <= vs_cur;
            end
         end
      end
   end

   assign vga_clk = tick;
   assign vga_r   = pix;
   assign vga_g   = pix;
   assign vga_b   = pix;

endmodule

// File: tb/tb_gpu_frame_reader.sv
// tb_gpu_frame_reader: randomized and directed checks of gpu_frame_reader
// against a closed-form model driven only by the count of enabled clocks.
// Vertical geometry is shrunk (12-line frame, 4-line window) so whole frames
// fit in a short run; horizontal timing and image width keep their defaults.
module tb_gpu_frame_reader;

   localparam int HT = 800, H_VIS_T = 640, HS0 = 656, HS1 = 752;
   localparam int VT = 12,  V_VIS_T = 8,   VS0 = 9,   VS1 = 11;
   localparam int IW = 128, IH = 2, SC = 2, XO = 192, YO = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en  = 1'b1;
   logic [31:0] GPUAddress, GPUData;
   logic        vga_clk, vga_hsync, vga_vsync, vga_blank_n, frame_done;
   logic [7:0]  vga_r, vga_g, vga_b;
   logic        ram_sync = 1'b0;
   logic [31:0] ram_q = '0;

   int errors = 0;
   int checks = 0;

   gpu_frame_reader #(
      .IMG_W(IW), .IMG_H(IH), .SCALE(SC), .X_OFF(XO), .Y_OFF(YO),
      .V_VIS(V_VIS_T), .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) dut (
      .clk(clk), .rst(rst), .en(en),
      .GPUAddress(GPUAddress), .GPUData(GPUData),
      .vga_clk(vga_clk), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
      .vga_blank_n(vga_blank_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // RAM holds mem[i] = i[7:0]; upper bits are junk the reader must ignore
   always @(negedge clk) ram_q <= {24'hC0FFEE, GPUAddress[7:0]};
   assign GPUData = ram_sync ? ram_q : {24'hDEAD5A, GPUAddress[7:0]};

   wire [60:0] act_vec = {GPUAddress, vga_clk, vga_hsync, vga_vsync, vga_blank_n,
                          vga_r, vga_g, vga_b, frame_done};

   // model state: enabled clocks since reset, video forced dark since en dropped
   longint n = 0;
   bit     forced = 1'b0;
   bit     last_en = 1'b0;

   always @(posedge clk) begin
      if (!rst) begin
         n <= 0; forced <= 1'b0; last_en <= 1'b0;
      end else if (en) begin
         n <= n + 1; last_en <= 1'b1;
         if ((n + 1) % 2 == 1) forced <= 1'b0;
      end else begin
         forced <= 1'b1; last_en <= 1'b0;
      end
   end

   function automatic void pos(input longint k, output int h, output int v);
      longint p;
      p = k % (HT*VT);
      h = int'(p % HT);
      v = int'(p / HT);
   endfunction

   function automatic bit in_win(input int h, input int v);
      return h >= XO && h < XO + IW*SC && v >= YO && v < YO + IH*SC;
   endfunction

   function automatic int addr_of(input int h, input int v);
      if (in_win(h, v)) return ((v - YO) / SC) * IW + (h - XO) / SC;
      return 0;
   endfunction

   // k-th pixel entry happens on enabled clock 2k; video shows the pixel
   // entered before the latest odd enabled clock
   function automatic logic [60:0] exp_vec();
      int h, v, eh, ev;
      logic hs, vs, bl, fd;
      logic [7:0] px;
      logic [31:0] ad;
      pos(n/2, h, v);
      ad = 32'(addr_of(h, v));
      hs = 1'b1; vs = 1'b1; bl = 1'b0; px = 8'd0;
      if (n > 0) begin
         pos((n-1)/2, eh, ev);
         hs = !(eh >= HS0 && eh < HS1);
         vs = !(ev >= VS0 && ev < VS1);
         if (!forced) begin
            bl = eh < H_VIS_T && ev < V_VIS_T;
            px = in_win(eh, ev) ? 8'(addr_of(eh, ev)) : 8'd0;
         end
      end
      fd = last_en && n > 0 && n % 2 == 0 && (n/2) % (HT*VT) == 0;
      return {ad, n % 2 == 1, hs, vs, bl, px, px, px, fd};
   endfunction

   task automatic goto(input int th, input int tv, output bit ok);
      int h, v;
      ok = 1'b0;
      for (int i = 0; i < 50000 && !ok; i++) begin
         @(negedge clk);
         if (n > 0 && n % 2 == 0) begin
            pos(n/2, h, v);
            if (h == th && v == tv) ok = 1'b1;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL goto_%0d_%0d: position not reached, n=%0d", th, tv, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; en = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (act_vec !== {32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_vals: got %h want %h", act_vec,
                     {32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0, 1'b0});
         end
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({vga_clk, vga_blank_n, GPUAddress} !== {1'b1, 1'b1, 32'd0}) begin
         errors++;
         $display("FAIL first_edge: got clk/blank/addr %b/%b/%0d want 1/1/0",
                  vga_clk, vga_blank_n, GPUAddress);
      end
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec()) begin
         errors++;
         $display("FAIL second_edge: got %h want %h", act_vec, exp_vec());
      end
   endtask

   task automatic test_free_run();
      int cyc = 0, hf = -1, hper = -1, hlow = -1, vf = -1, vlow = -1;
      int fdt = -1, fper = -1, fdn = 0;
      logic hs_p = 1'b1, vs_p = 1'b1;
      while (fdn < 2 && cyc < 45000) begin
         @(negedge clk);
         cyc++;
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++;
            $display("FAIL free_run cyc %0d: got %h want %h", cyc, act_vec, exp_vec());
         end
         if (hs_p && !vga_hsync) begin if (hf >= 0) hper = cyc - hf; hf = cyc; end
         if (!hs_p && vga_hsync && hf >= 0) hlow = cyc - hf;
         if (vs_p && !vga_vsync) vf = cyc;
         if (!vs_p && vga_vsync && vf >= 0) vlow = cyc - vf;
         if (frame_done) begin if (fdt >= 0) fper = cyc - fdt; fdt = cyc; fdn++; end
         hs_p = vga_hsync; vs_p = vga_vsync;
      end
      checks++;
      if (hper !== 1600) begin errors++; $display("FAIL hsync_period: got %0d want 1600", hper); end
      checks++;
      if (hlow !== 192) begin errors++; $display("FAIL hsync_low: got %0d want 192", hlow); end
      checks++;
      if (vlow !== 3200) begin errors++; $display("FAIL vsync_low: got %0d want 3200", vlow); end
      checks++;
      if (fper !== 2*HT*VT) begin errors++; $display("FAIL frame_period: got %0d want %0d", fper, 2*HT*VT); end
   endtask

   task automatic test_addr_map(input int th, input int tv, input int ea, input int ergb);
      bit ok;
      goto(th, tv, ok);
      checks++;
      if (GPUAddress !== 32'(ea)) begin
         errors++;
         $display("FAIL addr_%0d_%0d: got %0d want %0d", th, tv, GPUAddress, ea);
      end
      @(negedge clk);
      checks++;
      if ({vga_r, vga_g, vga_b} !== {3{8'(ergb)}}) begin
         errors++;
         $display("FAIL rgb_%0d_%0d: got %0d/%0d/%0d want %0d", th, tv, vga_r, vga_g, vga_b, ergb);
      end
   endtask

   task automatic test_ram(input logic mode, input int th, input int tv);
      bit ok;
      ram_sync = mode;
      goto(th, tv, ok);
      checks++;
      if ({GPUAddress, vga_r} !== {32'd5, 8'd4}) begin
         errors++;
         $display("FAIL ram%0d_addr: got addr %0d rgb %0d want 5/4", mode, GPUAddress, vga_r);
      end
      @(negedge clk);
      checks++;
      if ({GPUAddress, vga_r, vga_g, vga_b, vga_blank_n} !== {32'd5, 8'd5, 8'd5, 8'd5, 1'b1}) begin
         errors++;
         $display("FAIL ram%0d_data: got addr %0d rgb %0d/%0d/%0d blank_n %b want 5/5 1",
                  mode, GPUAddress, vga_r, vga_g, vga_b, vga_blank_n);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      goto(100, 7, ok);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (act_vec !== {32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0, 1'b0}) begin
         errors++;
         $display("FAIL mid_reset: got %h want %h", act_vec,
                  {32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0, 1'b0});
      end
      rst = 1'b1;
      repeat (8) begin
         @(negedge clk);
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++;
            $display("FAIL mid_restart: got %h want %h", act_vec, exp_vec());
         end
      end
   endtask

   task automatic test_enable();
      bit ok;
      logic vc, hs, vs;
      goto(300, 4, ok);
      vc = vga_clk; hs = vga_hsync; vs = vga_vsync;
      en = 1'b0;
      repeat (10) begin
         @(negedge clk);
         checks++;
         if ({GPUAddress, vga_clk, vga_hsync, vga_vsync, vga_blank_n, vga_r, frame_done} !==
             {32'd182, vc, hs, vs, 1'b0, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL en_hold: got addr %0d clk %b hs %b vs %b blank_n %b rgb %0d fd %b want 182 %b %b %b 0 0 0",
                     GPUAddress, vga_clk, vga_hsync, vga_vsync, vga_blank_n, vga_r, frame_done, vc, hs, vs);
         end
      end
      en = 1'b1;
      @(negedge clk);
      checks++;
      if ({vga_blank_n, vga_r} !== {1'b1, 8'd182}) begin
         errors++;
         $display("FAIL en_resume: got blank_n %b rgb %0d want 1 182", vga_blank_n, vga_r);
      end
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++;
            $display("FAIL en_track: got %h want %h", act_vec, exp_vec());
         end
      end
      checks++;
      if (GPUAddress !== 32'd183) begin
         errors++;
         $display("FAIL en_next_addr: got %0d want 183", GPUAddress);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         checks++;
         if (act_vec !== exp_vec()) begin
            errors++;
            $display("FAIL random cyc %0d: got %h want %h", i, act_vec, exp_vec());
         end
         en  = ($urandom_range(0, 9) != 0);
         rst = ($urandom_range(0, 299) != 0);
      end
      rst = 1'b1; en = 1'b1;
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_addr_map(192, 2, 0, 0);
      test_addr_map(194, 2, 1, 1);
      test_ram(1'b0, 202, 2);
      test_ram(1'b1, 202, 3);
      test_addr_map(448, 3, 0, 0);
      test_addr_map(192, 4, 128, 128);
      test_addr_map(447, 5, 255, 255);
      test_reset_mid();
      test_enable();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: run exceeded time limit, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
